psg_bus_ctrl: RTL and testbench
===============================

PSG_BUS_CTRL -- requirements
Module: psg_bus_ctrl

Interface
REQ-001 Parameter: ADDR_HI, default 4'h0, upper address nibble that selects this chip.
REQ-002 Port: clk  input  1  system clock; all state changes on its rising edge.
REQ-003 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-004 Port: bdir, bc1  input  1 each  bus mode: 00 inactive, 01 read, 10 write, 11 latch address; synchronous to clk.
REQ-005 Port: data_in  input  8  bus data; holds the address in latch mode and the write data in write mode.
REQ-006 Port: data_out  output  8  read data.
REQ-007 Port: data_oe  output  1  read-data output enable.
REQ-008 Port: tone_period_a/b/c  output  12 each  {R1[3:0],R0}, {R3[3:0],R2}, {R5[3:0],R4}.
REQ-009 Port: noise_period  output  5  R6[4:0], the noise generator period.
REQ-010 Port: mixer  output  6  R7[5:0] (tone/noise disables).
REQ-011 Port: amp_a/b/c  output  5 each  R8[4:0], R9[4:0], R10[4:0].
REQ-012 Port: env_period  output  16  {R12,R11}.
REQ-013 Port: env_shape  output  4  R13[3:0].
REQ-014 Port: env_restart  output  1  one-cycle pulse on each committed R13 write.

Function
REQ-015 FSM states: IDLE, LATCH, WRITE, READ; the next state is decoded from {bdir,bc1} every cycle (00->IDLE, 11->LATCH, 10->WRITE, 01->READ).
REQ-016 In LATCH, every cycle captures addr = data_in[3:0] and sets sel = (data_in[7:4] == ADDR_HI).
REQ-017 In WRITE, every cycle captures data_in into a hold register; the last captured value wins.
REQ-018 Commit occurs on the first cycle after leaving WRITE, whatever the next mode; if sel=1, the register at addr is updated with the hold value, visible on outputs one cycle later.
REQ-019 Stored width per register: R1/R3/R5/R13 4 bits; R6/R8/R9/R10 5 bits; R0/R2/R4/R7/R11/R12 8 bits; unused high bits are discarded at write.
REQ-020 R14 and R15 (I/O ports) are writable and readable as 8 bits, with no other output.
REQ-021 Commit with sel=0, or with no address latched since reset, is ignored with no side effects.
REQ-022 env_restart is high exactly the cycle R13 is updated, including rewrites of the same value.
REQ-023 addr and sel persist across multiple writes; repeated WRITE phases without a new LATCH all go to the same register.
REQ-024 If LATCH directly follows WRITE, the commit uses the addr that was valid during that WRITE; the new address applies only to later writes.
REQ-025 All outputs are registered; no combinational path from bus inputs to outputs.

Reset
REQ-026 reset_n low clears all 16 registers, addr, sel and the hold register to 0, forces state to IDLE, and forces data_oe=0 and env_restart=0, all immediately.
REQ-027 Reset during WRITE aborts the pending commit; no register changes after release until a new LATCH+WRITE sequence.
REQ-028 After release, noise_period=0, all tone periods=0, mixer=0, and env_restart=0.

Configuration
REQ-029 Macro PSG_READBACK_EN defined: in READ with sel=1, data_out = zero-extended register[addr] and data_oe=1, both registered (one-cycle latency); otherwise data_oe=0 and data_out=0.
REQ-030 Macro PSG_READBACK_EN undefined: data_out=0 and data_oe=0 permanently, and no read multiplexer is synthesised.

Verification
REQ-031 LATCH 8'h06, WRITE 8'hFF, IDLE -> noise_period=5'h1F two cycles after WRITE ends; no other output changes.
REQ-032 LATCH 8'h0D, WRITE 8'h0A, IDLE, then WRITE 8'h0A again -> env_shape=4'hA and two single-cycle env_restart pulses.
REQ-033 LATCH 8'h16 (upper nibble 1, ADDR_HI=0), WRITE 8'h11 -> noise_period unchanged; READ gives data_oe=0.
REQ-034 LATCH 8'h01, WRITE 8'hF7 -> tone_period_a[11:8]=4'h7; with PSG_READBACK_EN, READ returns data_out=8'h07, data_oe=1.
REQ-035 Reset_n pulsed low mid-WRITE of 8'h1F to R6 -> noise_period stays 0 and a following WRITE with no LATCH is ignored.
REQ-036 WRITE 8'h05 to R8, then LATCH 8'h09 in the very next cycle -> amp_a=5'h05 and amp_b unchanged.

Source files
------------

// File: rtl/psg_bus_ctrl.sv
// PSG bus interface and register file: decodes the bdir/bc1 bus, latches address and data,
// commits writes and exposes the sixteen sound registers. Optional readback: PSG_READBACK_EN.
module psg_bus_ctrl #(
  parameter logic [3:0] ADDR_HI = 4'h0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        bdir,
  input  logic        bc1,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  output logic        data_oe,
  output logic [11:0] tone_period_a,
  output logic [11:0] tone_period_b,
  output logic [11:0] tone_period_c,
  output logic [4:0]  noise_period,
  output logic [5:0]  mixer,
  output logic [4:0]  amp_a,
  output logic [4:0]  amp_b,
  output logic [4:0]  amp_c,
  output logic [15:0] env_period,
  output logic [3:0]  env_shape,
  output logic        env_restart
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    LATCH = 2'b11
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  addr_q, addr_d;
  logic        sel_q, sel_d;
  logic [7:0]  hold_q, hold_d;
  logic [7:0]  regs_q [16];
  logic        restart_q, restart_d;
  logic        wr_en;
  logic [7:0]  wr_mask;
  logic [7:0]  wr_data;

  always_comb begin
    state_d   = IDLE;
    addr_d    = addr_q;
    sel_d     = sel_q;
    hold_d    = hold_q;
    wr_mask   = 8'hFF;
    unique case ({bdir, bc1})
      2'b00:   state_d = IDLE;
      2'b01:   state_d = READ;
      2'b10:   state_d = WRITE;
      default: state_d = LATCH;
    endcase
    // Commit uses the address held during the WRITE phase, even if a LATCH replaces it this cycle.
    wr_en     = (state_q == WRITE) && (state_d != WRITE) && sel_q;
    unique case (addr_q)
      4'd1, 4'd3, 4'd5, 4'd13:  wr_mask = 8'h0F;
      4'd6, 4'd8, 4'd9, 4'd10:  wr_mask = 8'h1F;
      default:                  wr_mask = 8'hFF;
    endcase
    wr_data   = hold_q & wr_mask;
    restart_d = wr_en && (addr_q == 4'd13);
    if (state_d == LATCH) begin
      addr_d = data_in[3:0];
      sel_d  = (data_in[7:4] == ADDR_HI);
    end
    if (state_d == WRITE) begin
      hold_d = data_in;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      sel_q     <= 1'b0;
      hold_q    <= '0;
      restart_q <= 1'b0;
      for (int unsigned i = 0; i < 16; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      sel_q     <= sel_d;
      hold_q    <= hold_d;
      restart_q <= restart_d;
      if (wr_en) begin
        regs_q[addr_q] <= wr_data;
      end
    end
  end

  assign tone_period_a = {regs_q[1][3:0], regs_q[0]};
  assign tone_period_b = {regs_q[3][3:0], regs_q[2]};
  assign tone_period_c = {regs_q[5][3:0], regs_q[4]};
  assign noise_period  = regs_q[6][4:0];
  assign mixer         = regs_q[7][5:0];
  assign amp_a         = regs_q[8][4:0];
  assign amp_b         = regs_q[9][4:0];
  assign amp_c         = regs_q[10][4:0];
  assign env_period    = {regs_q[12], regs_q[11]};
  assign env_shape     = regs_q[13][3:0];
  assign env_restart   = restart_q;

`ifdef PSG_READBACK_EN
  logic [7:0] dout_q;
  logic       doe_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dout_q <= '0;
      doe_q  <= 1'b0;
    end else if ((state_d == READ) && sel_q) begin
      dout_q <= regs_q[addr_q];
      doe_q  <= 1'b1;
    end else begin
      dout_q <= '0;
      doe_q  <= 1'b0;
    end
  end

  assign data_out = dout_q;
  assign data_oe  = doe_q;
`else
  // Bits only visible through readback; the reduction keeps them named but drives nothing.
  logic unused_bits;
  assign unused_bits = ^{regs_q[14], regs_q[15], regs_q[1][7:4], regs_q[3][7:4],
                         regs_q[5][7:4], regs_q[13][7:4], regs_q[6][7:5], regs_q[7][7:6],
                         regs_q[8][7:5], regs_q[9][7:5], regs_q[10][7:5]};
  assign data_out = '0;
  assign data_oe  = 1'b0;
`endif

endmodule

// File: tb/tb_psg_bus_ctrl.sv
// Scoreboard bench for psg_bus_ctrl: a transaction-level register model predicts every output
// for each bus cycle; a monitor compares them against the DUT one cycle later.
module tb_psg_bus_ctrl;

  localparam logic [3:0] TB_HI   = 4'h0;
  localparam logic [1:0] M_IDLE  = 2'b00;
  localparam logic [1:0] M_READ  = 2'b01;
  localparam logic [1:0] M_WRITE = 2'b10;
  localparam logic [1:0] M_LATCH = 2'b11;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        bdir, bc1;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic        data_oe;
  logic [11:0] tone_period_a, tone_period_b, tone_period_c;
  logic [4:0]  noise_period;
  logic [5:0]  mixer;
  logic [4:0]  amp_a, amp_b, amp_c;
  logic [15:0] env_period;
  logic [3:0]  env_shape;
  logic        env_restart;

  psg_bus_ctrl #(.ADDR_HI(TB_HI)) dut (
    .clk(clk), .reset_n(reset_n), .bdir(bdir), .bc1(bc1), .data_in(data_in),
    .data_out(data_out), .data_oe(data_oe),
    .tone_period_a(tone_period_a), .tone_period_b(tone_period_b), .tone_period_c(tone_period_c),
    .noise_period(noise_period), .mixer(mixer),
    .amp_a(amp_a), .amp_b(amp_b), .amp_c(amp_c),
    .env_period(env_period), .env_shape(env_shape), .env_restart(env_restart)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] ta, tb, tc;
    logic [4:0]  np;
    logic [5:0]  mx;
    logic [4:0]  aa, ab, ac;
    logic [15:0] ep;
    logic [3:0]  es;
    logic        er;
    logic [7:0]  dout;
    logic        doe;
  } exp_t;

  exp_t        expq[$];
  int unsigned n_chk = 0;
  int unsigned n_bad = 0;

  // Reference model: the register file as the bus sees it, written one transaction at a time.
  logic [7:0]  m_regs [16];
  logic [3:0]  m_addr;
  logic        m_sel;
  logic [7:0]  m_hold;
  logic [1:0]  m_prev;
  int unsigned reg_w [16] = '{8, 4, 8, 4, 8, 4, 5, 8, 5, 5, 5, 8, 8, 4, 8, 8};

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
    n_chk++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
    m_addr = 4'h0;
    m_sel  = 1'b0;
    m_hold = 8'h00;
    m_prev = M_IDLE;
    expq.delete();
  endtask

  task automatic model_step(input logic [1:0] mode, input logic [7:0] d);
    exp_t e;
    int unsigned lim;
    e.dout = 8'h00;
    e.doe  = 1'b0;
`ifdef PSG_READBACK_EN
    if (mode == M_READ && m_sel) begin
      e.dout = m_regs[m_addr];
      e.doe  = 1'b1;
    end
`endif
    e.er = 1'b0;
    if (m_prev == M_WRITE && mode != M_WRITE && m_sel) begin
      lim = (32'd1 << reg_w[m_addr]) - 1;
      m_regs[m_addr] = 8'(32'(m_hold) & lim);
      e.er = (m_addr == 4'd13);
    end
    if (mode == M_LATCH) begin
      m_addr = d[3:0];
      m_sel  = (d[7:4] == TB_HI);
    end
    if (mode == M_WRITE) m_hold = d;
    m_prev = mode;
    e.ta = {m_regs[1][3:0], m_regs[0]};
    e.tb = {m_regs[3][3:0], m_regs[2]};
    e.tc = {m_regs[5][3:0], m_regs[4]};
    e.np = m_regs[6][4:0];
    e.mx = m_regs[7][5:0];
    e.aa = m_regs[8][4:0];
    e.ab = m_regs[9][4:0];
    e.ac = m_regs[10][4:0];
    e.ep = {m_regs[12], m_regs[11]};
    e.es = m_regs[13][3:0];
    expq.push_back(e);
  endtask

  // One bus cycle: drive mode/data for the next rising edge and predict the result.
  task automatic bus(input logic [1:0] mode, input logic [7:0] d);
    @(posedge clk);
    #2;
    {bdir, bc1} = mode;
    data_in     = d;
    model_step(mode, d);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("rst_oe", 16'(data_oe), 16'h0);
    chk("rst_restart", 16'(env_restart), 16'h0);
    chk("rst_noise", 16'(noise_period), 16'h0);
    chk("rst_tone_a", 16'(tone_period_a), 16'h0);
    repeat (2) @(posedge clk);
    #2;
    {bdir, bc1} = M_IDLE;
    data_in     = 8'h00;
    reset_n     = 1'b1;
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (reset_n && expq.size() > 0) begin
      e = expq.pop_front();
      chk("tone_a", 16'(tone_period_a), 16'(e.ta));
      chk("tone_b", 16'(tone_period_b), 16'(e.tb));
      chk("tone_c", 16'(tone_period_c), 16'(e.tc));
      chk("noise", 16'(noise_period), 16'(e.np));
      chk("mixer", 16'(mixer), 16'(e.mx));
      chk("amp_a", 16'(amp_a), 16'(e.aa));
      chk("amp_b", 16'(amp_b), 16'(e.ab));
      chk("amp_c", 16'(amp_c), 16'(e.ac));
      chk("env_period", env_period, e.ep);
      chk("env_shape", 16'(env_shape), 16'(e.es));
      chk("env_restart", 16'(env_restart), 16'(e.er));
      chk("data_out", 16'(data_out), 16'(e.dout));
      chk("data_oe", 16'(data_oe), 16'(e.doe));
    end
  end

  initial begin
    logic [7:0] d;
    logic [1:0] m;
    reset_n = 1'b0;
    {bdir, bc1} = M_IDLE;
    data_in = 8'h00;
    model_reset();
    #3;
    chk("init_oe", 16'(data_oe), 16'h0);
    chk("init_restart", 16'(env_restart), 16'h0);
    chk("init_mixer", 16'(mixer), 16'h0);
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;
    bus(M_IDLE, 8'h00);
    chk("post_rst_noise", 16'(noise_period), 16'h0);
    chk("post_rst_tone_c", 16'(tone_period_c), 16'h0);

    // Noise period write, visible two cycles after the WRITE phase
    bus(M_LATCH, 8'h06); bus(M_WRITE, 8'hFF); bus(M_IDLE, 8'h00); bus(M_IDLE, 8'h00);
    chk("d031_noise", 16'(noise_period), 16'h1F);
    chk("d031_amp_a", 16'(amp_a), 16'h0);

    // Envelope shape rewritten twice: two single-cycle restart pulses
    bus(M_LATCH, 8'h0D); bus(M_WRITE, 8'h0A); bus(M_IDLE, 8'h00);
    bus(M_WRITE, 8'h0A);
    chk("d032_pulse1", 16'(env_restart), 16'h1);
    chk("d032_shape", 16'(env_shape), 16'hA);
    bus(M_IDLE, 8'h00);
    chk("d032_gap", 16'(env_restart), 16'h0);
    bus(M_IDLE, 8'h00);
    chk("d032_pulse2", 16'(env_restart), 16'h1);
    bus(M_IDLE, 8'h00);
    chk("d032_end", 16'(env_restart), 16'h0);

    // Foreign chip address
    bus(M_LATCH, 8'h16); bus(M_WRITE, 8'h11); bus(M_IDLE, 8'h00); bus(M_READ, 8'h00);
    bus(M_IDLE, 8'h00);
    chk("d033_noise", 16'(noise_period), 16'h1F);
    chk("d033_oe", 16'(data_oe), 16'h0);

    // High nibble of a 4-bit register discarded
    bus(M_LATCH, 8'h01); bus(M_WRITE, 8'hF7); bus(M_IDLE, 8'h00); bus(M_READ, 8'h00);
    bus(M_IDLE, 8'h00);
    chk("d034_tone_hi", 16'(tone_period_a[11:8]), 16'h7);
`ifdef PSG_READBACK_EN
    chk("d034_dout", 16'(data_out), 16'h07);
    chk("d034_oe", 16'(data_oe), 16'h1);
`else
    chk("d034_dout", 16'(data_out), 16'h00);
    chk("d034_oe", 16'(data_oe), 16'h0);
`endif

    // Reset in the middle of a WRITE phase
    do_reset();
    bus(M_LATCH, 8'h06); bus(M_WRITE, 8'h1F);
    do_reset();
    chk("d035_noise_rel", 16'(noise_period), 16'h0);
    bus(M_WRITE, 8'h1F); bus(M_IDLE, 8'h00); bus(M_IDLE, 8'h00);
    chk("d035_noise", 16'(noise_period), 16'h0);

    // LATCH right after WRITE commits to the old address
    bus(M_LATCH, 8'h08); bus(M_WRITE, 8'h05); bus(M_LATCH, 8'h09); bus(M_IDLE, 8'h00);
    chk("d036_amp_a", 16'(amp_a), 16'h05);
    chk("d036_amp_b", 16'(amp_b), 16'h00);

    for (int i = 0; i < 3000; i++) begin
      m = 2'($urandom_range(0, 3));
      d = 8'($urandom);
      if ($urandom_range(0, 3) != 0) d[7:4] = TB_HI;
      bus(m, d);
    end
    bus(M_IDLE, 8'h00);
    bus(M_IDLE, 8'h00);
    for (int i = 0; i < 5 && expq.size() != 0; i++) @(posedge clk);
    #3;
    if (expq.size() != 0) begin
      n_chk++;
      n_bad++;
      $display("FAIL drain: %0d pending expected 0", expq.size());
    end
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
